// File: rtl/flow_pkg.sv
// Shared definitions for the instruction flow blocks (fetch, decode, regfile).
package flow_pkg;

   localparam int WORD_W = 16;

   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting on memory; expired marks the last allowed cycle.
module fetch_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMEOUT_W      = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + TIMEOUT_W'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter owner: fetches instruction words over a req/ack handshake and
// holds each one for the decoder until it advances or redirects.
module instruction_fetch_unit
   import flow_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC       = RESET_PC_DEFAULT,
   parameter int                TIMEOUT_CYCLES = 16,
   parameter int                TIMEOUT_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] instruction,
   output logic              instruction_valid,
   input  logic              program_counter_increment,
   input  logic              jump_enable,
   input  logic [WORD_W-1:0] jump_target,
   input  logic              stall,
   output logic [WORD_W-1:0] pc,
   output logic              fetch_error
);

   // state | meaning
   // FETCH | raise request for the word at pc
   // WAIT  | request outstanding, timeout counter running
   // HOLD  | word valid for the decoder, waiting for advance or redirect
   // HALT  | fetch timed out, frozen until reset

   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [WORD_W-1:0] pc_next;
   logic [WORD_W-1:0] instruction_next;
   logic              error_next;
   logic              tmo_clear;
   logic              tmo_enable;
   logic              tmo_expired;

   fetch_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_W     (TIMEOUT_W)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (tmo_clear),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_FETCH;
         pc          <= RESET_PC;
         instruction <= '0;
         fetch_error <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instruction <= instruction_next;
         fetch_error <= error_next;
      end
   end

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      instruction_next = instruction;
      error_next       = fetch_error;
      tmo_clear        = 1'b1;
      tmo_enable       = 1'b0;
      case (state)
         ST_FETCH: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // An ack on the threshold cycle still wins over the timeout.
            if (mem_ack) begin
               instruction_next = mem_rdata;
               state_next       = ST_HOLD;
            end else if (tmo_expired) begin
               error_next = 1'b1;
               state_next = ST_HALT;
            end else begin
               tmo_clear  = 1'b0;
               tmo_enable = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!stall) begin
               if (jump_enable) begin
                  pc_next    = jump_target;
                  state_next = ST_FETCH;
               end else if (program_counter_increment) begin
                  pc_next    = pc + 16'd1;
                  state_next = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   // Gated by rst so memory never sees a request while reset is held.
   assign mem_req           = ((state == ST_FETCH) || (state == ST_WAIT)) && !rst;
   assign mem_addr          = pc;
   assign instruction_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed steps plus randomized advances,
// checked against a PC/memory reference model.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instruction;
   logic        instruction_valid;
   logic        program_counter_increment;
   logic        jump_enable;
   logic [15:0] jump_target;
   logic        stall;
   logic [15:0] pc;
   logic        fetch_error;

   int          n_assert;
   int          n_fail;
   int          lat;
   bit          never_ack;
   int          req_cnt;
   logic [15:0] exp_pc;

   instruction_fetch_unit #(
      .RESET_PC      (16'h0000),
      .TIMEOUT_CYCLES(4),
      .TIMEOUT_W     (3)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .mem_req                  (mem_req),
      .mem_addr                 (mem_addr),
      .mem_ack                  (mem_ack),
      .mem_rdata                (mem_rdata),
      .instruction              (instruction),
      .instruction_valid        (instruction_valid),
      .program_counter_increment(program_counter_increment),
      .jump_enable              (jump_enable),
      .jump_target              (jump_target),
      .stall                    (stall),
      .pc                       (pc),
      .fetch_error              (fetch_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory contents: fixed word at 0, hashed elsewhere.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] p;
      p = 16'(a * 16'h9E37);
      return (a == 16'h0000) ? 16'h1234 : (p ^ 16'h5A5A);
   endfunction

   // Memory responder: acks after `lat` empty WAIT cycles, noise when idle.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      req_cnt   = 0;
      forever begin
         @(negedge clk);
         #1;
         if (mem_req === 1'b1) begin
            req_cnt   = req_cnt + 1;
            mem_ack   = !never_ack && (req_cnt >= 2 + lat);
            mem_rdata = mem_ack ? mem_word(mem_addr) : 16'($urandom);
         end else begin
            req_cnt   = 0;
            mem_ack   = 1'($urandom);
            mem_rdata = 16'($urandom);
         end
      end
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_noise();
      program_counter_increment = 1'($urandom);
      jump_enable               = 1'($urandom);
      stall                     = 1'($urandom);
      jump_target               = 16'($urandom);
   endtask

   task automatic clear_inputs();
      program_counter_increment = 1'b0;
      jump_enable               = 1'b0;
      stall                     = 1'b0;
   endtask

   // Called at a negedge; leaves rst released at a negedge with FETCH next.
   task automatic apply_reset(input int n);
      rst = 1'b1;
      drive_noise();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check1 ("rst_mem_req",  mem_req,           1'b0);
         check1 ("rst_valid",    instruction_valid, 1'b0);
         check1 ("rst_error",    fetch_error,       1'b0);
         check16("rst_pc",       pc,                16'h0000);
         check16("rst_instr",    instruction,       16'h0000);
         drive_noise();
      end
      rst = 1'b0;
      clear_inputs();
      exp_pc = 16'h0000;
   endtask

   // Waits for the word at exp_pc to become valid within a cycle budget.
   task automatic wait_fetch(input int exp_cycles);
      int cyc;
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check1 ("fetch_req",  mem_req,  1'b1);
            check16("fetch_addr", mem_addr, exp_pc);
         end
         if (instruction_valid === 1'b1) begin
            cyc = i;
            break;
         end
         check16("fetch_addr_hold", mem_addr, exp_pc);
         drive_noise();
      end
      clear_inputs();
      check32("fetch_latency", cyc, exp_cycles);
      check16("fetch_instr",   instruction, mem_word(exp_pc));
      check16("fetch_pc",      pc,          exp_pc);
   endtask

   // kind: 0 increment, 1 jump, 2 jump and increment together
   task automatic issue(input int kind, input logic [15:0] target);
      stall                     = 1'b0;
      program_counter_increment = (kind != 1);
      jump_enable               = (kind != 0);
      jump_target               = target;
      exp_pc = (kind == 0) ? exp_pc + 16'd1 : target;
   endtask

   task automatic stall_hold(input int n, input bit force_both);
      for (int i = 0; i < n; i++) begin
         stall                     = 1'b1;
         program_counter_increment = force_both ? 1'b1 : 1'($urandom);
         jump_enable               = force_both ? 1'b1 : 1'($urandom);
         jump_target               = 16'($urandom);
         @(negedge clk);
         check1 ("stall_valid", instruction_valid, 1'b1);
         check16("stall_pc",    pc,                exp_pc);
         check16("stall_instr", instruction,       mem_word(exp_pc));
      end
      clear_inputs();
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      lat         = 0;
      never_ack   = 1'b0;
      exp_pc      = 16'h0000;
      rst         = 1'b1;
      jump_target = 16'h0000;
      clear_inputs();

      apply_reset(3);
      wait_fetch(2);

      issue(0, 16'h0000);
      wait_fetch(3);

      issue(2, 16'h00F0);
      wait_fetch(3);

      stall_hold(5, 1'b1);
      issue(0, 16'h0000);
      wait_fetch(3);

      issue(1, 16'hFFFF);
      wait_fetch(3);
      issue(0, 16'h0000);
      wait_fetch(3);

      lat = 3;
      issue(1, 16'h0BAD);
      wait_fetch(6);

      for (int k = 0; k < 30; k++) begin
         int kind;
         lat  = int'($urandom_range(0, 3));
         kind = int'($urandom_range(0, 3));
         if (kind == 3) begin
            stall_hold(int'($urandom_range(1, 3)), 1'b0);
            kind = int'($urandom_range(0, 2));
         end
         issue(kind, 16'($urandom));
         wait_fetch(3 + lat);
      end

      // Timeout: FETCH plus four empty WAIT cycles, then HALT.
      never_ack = 1'b1;
      issue(0, 16'h0000);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check1("tmo_error", fetch_error, (i == 6));
         check1("tmo_req",   mem_req,     (i != 6));
         drive_noise();
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check16("halt_pc",    pc,                exp_pc);
         check1 ("halt_error", fetch_error,       1'b1);
         check1 ("halt_req",   mem_req,           1'b0);
         check1 ("halt_valid", instruction_valid, 1'b0);
         drive_noise();
      end
      never_ack = 1'b0;
      apply_reset(2);
      lat = 0;
      wait_fetch(2);

      // Reset in the middle of WAIT, then a fetch at the timeout boundary.
      never_ack = 1'b1;
      issue(0, 16'h0000);
      repeat (3) begin
         @(negedge clk);
         drive_noise();
      end
      apply_reset(1);
      never_ack = 1'b0;
      lat = 3;
      wait_fetch(5);
      check1("final_error", fetch_error, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the ALU instruction decoder.
- Owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and holds the current word stable on `instruction` while the decoder consumes it.
- Advances on the decoder's `program_counter_increment`. Redirects on a jump request.
- Reports a fetch timeout as a sticky error bit.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYCLES, 16, cycles waiting for mem_ack before fetch_error is raised (min 1)
- TIMEOUT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  16  word address of the fetch; equals pc while mem_req=1
- mem_ack  in  1  memory returns data this cycle; only sampled while mem_req=1
- mem_rdata  in  16  instruction word, valid when mem_ack=1
- instruction  out  16  current instruction word to the decoder
- instruction_valid  out  1  instruction holds a fetched word for pc
- program_counter_increment  in  1  decoder consumes current word; advance pc by 1
- jump_enable  in  1  redirect pc to jump_target
- jump_target  in  16  absolute target address
- stall  in  1  freeze advance/redirect (downstream busy)
- pc  out  16  address of the word in `instruction` (or being fetched)
- fetch_error  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-fetch):
  - pc=RESET_PC, state=FETCH, mem_req=0, instruction=16'h0000, instruction_valid=0, fetch_error=0, timeout counter=0.
  - A mem_ack arriving during reset is ignored.
- States: FETCH, WAIT, HOLD, HALT.
- FETCH:
  - mem_req=1, mem_addr=pc, go to WAIT next cycle. mem_req stays 1 through WAIT.
- WAIT:
  - mem_req=1, mem_addr=pc, held constant until ack.
  - mem_ack=1 → instruction<=mem_rdata, instruction_valid<=1, counter<=0, go to HOLD.
  - Minimum latency: pc change → instruction_valid is 2 cycles.
  - mem_ack=0 → counter+1. When counter reaches TIMEOUT_CYCLES-1 without ack: fetch_error<=1, mem_req<=0, go to HALT.
- HOLD:
  - mem_req=0; instruction and pc held stable.
  - Advance is taken only if stall=0.
  - jump_enable=1 → pc<=jump_target, instruction_valid<=0, go to FETCH.
  - else program_counter_increment=1 → pc<=pc+1 (mod 2^16, 16'hFFFF wraps to 16'h0000), instruction_valid<=0, go to FETCH.
  - Jump takes priority when both jump_enable and program_counter_increment are asserted.
  - stall=1 → no change, regardless of jump_enable/increment.
- HALT:
  - mem_req=0, instruction_valid=0, pc frozen. All inputs ignored until rst.
- Increment/jump outside HOLD (FETCH/WAIT/HALT) are ignored; the decoder is only presented valid words.
- mem_ack outside WAIT is ignored.
- An ack on the same edge as the timeout threshold counts as success; no error.
- Throughput: 1 instruction per 3 cycles at zero-wait memory (FETCH, WAIT, HOLD). Prefetch is out of scope.

Decomposition:
- Shared package `flow_pkg`:
  - fetch state enum (FETCH/WAIT/HOLD/HALT, 2-bit encoding)
  - `WORD_W=16`
  - `RESET_PC` default constant, also used by the decoder/regfile benches
- One natural sub-module: `fetch_timeout_counter` (clear/enable/expired; parameterised by TIMEOUT_CYCLES and TIMEOUT_W).
- Everything else is flat in `instruction_fetch_unit`.

Test Plan:
- Reset then zero-wait memory returning 16'h1234 at addr 0 → mem_req at cycle 1 with mem_addr=0; instruction=16'h1234, instruction_valid=1 at cycle 2; pc=0.
- HOLD with program_counter_increment=1, stall=0 → pc=1, instruction_valid drops for 2 cycles; next fetch at mem_addr=1.
- HOLD with jump_enable=1, jump_target=16'h00F0, and program_counter_increment=1 simultaneously → pc=16'h00F0 (jump wins); next mem_addr=16'h00F0.
- HOLD with stall=1 plus increment and jump held for 5 cycles → pc, instruction, instruction_valid unchanged; advance occurs on the first cycle stall=0.
- pc=16'hFFFF, increment → pc=16'h0000, fetch at address 0.
- TIMEOUT_CYCLES=4, mem_ack never asserted → fetch_error=1 after 4 WAIT cycles, mem_req=0, HALT holds. rst mid-WAIT in a separate run → clean restart at RESET_PC with fetch_error=0.
